// File: rtl/fma16_arbiter.sv
// fma16_arbiter: round-robin arbiter/sequencer sharing one combinational fma16
// datapath among NREQ requesters. Operands are registered onto the fma16 inputs
// and held for MC_CYCLES cycles (multicycle path), then the result and flags are
// captured and returned on a valid/ready response channel tagged with the
// requester id. A sticky accrued-flags register collects every captured flag set.
module fma16_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MC_CYCLES = 2,
  parameter int unsigned IDW       = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // request side
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  input  logic [16*NREQ-1:0]   req_z,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [2*NREQ-1:0]    req_rm,
  // response side
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic [IDW-1:0]       rsp_id,
  // shared fma16 datapath
  output logic [15:0]          fma_x,
  output logic [15:0]          fma_y,
  output logic [15:0]          fma_z,
  output logic                 fma_mul,
  output logic                 fma_add,
  output logic                 fma_negr,
  output logic                 fma_negz,
  output logic [1:0]           fma_rm,
  input  logic [15:0]          fma_result,
  input  logic [3:0]           fma_flags,
  // status
  output logic [3:0]           acc_flags,
  input  logic                 flag_clr,
  output logic                 busy
);

  // Counter must be at least one bit wide even when MC_CYCLES == 1.
  localparam int unsigned CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] rot_valid;
  logic [IDW-1:0]  grant;
  logic            grant_vld;
  logic            accept;
  logic            capture;
  logic            rsp_done;

  logic [15:0]     sel_x, sel_y, sel_z;
  logic [3:0]      sel_op;
  logic [1:0]      sel_rm;

  logic [15:0]     fma_x_q, fma_y_q, fma_z_q;
  logic [3:0]      fma_op_q;
  logic [1:0]      fma_rm_q;
  logic            rsp_valid_q;
  logic [15:0]     rsp_result_q;
  logic [3:0]      rsp_flags_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [3:0]      acc_flags_q;

  // Rotate the valid vector so bit 0 is the current round-robin head.
  assign rot_valid = NREQ'({req_valid, req_valid} >> rr_q);

  // Grant: first valid requester at or after rr, wrapping modulo NREQ.
  always_comb begin
    int unsigned sum;
    grant     = '0;
    grant_vld = 1'b0;
    sum       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_vld && rot_valid[IDW'(i)]) begin
        sum = 32'(rr_q) + i;
        if (sum >= NREQ) sum = sum - NREQ;
        grant     = IDW'(sum);
        grant_vld = 1'b1;
      end
    end
  end

  // Operand mux for the granted requester.
  assign sel_x  = 16'(req_x >> {grant, 4'h0});
  assign sel_y  = 16'(req_y >> {grant, 4'h0});
  assign sel_z  = 16'(req_z >> {grant, 4'h0});
  assign sel_op = 4'(req_op >> {grant, 2'b00});
  assign sel_rm = 2'(req_rm >> {grant, 1'b0});

  // Ready is gated by reset_n so nothing is offered while reset is asserted.
  assign req_ready = (state_q == StIdle && grant_vld && reset_n) ?
                     (NREQ'(1) << grant) : '0;

  // Next-state logic and per-cycle strobes.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          accept  = 1'b1;
          state_d = StExec;
          cnt_d   = CW'(MC_CYCLES - 1);
          rr_d    = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state: FSM, round-robin pointer and hold counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // fma16 input registers: loaded on accept, otherwise held (never cleared).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fma_x_q  <= '0;
      fma_y_q  <= '0;
      fma_z_q  <= '0;
      fma_op_q <= '0;
      fma_rm_q <= '0;
    end else if (accept) begin
      fma_x_q  <= sel_x;
      fma_y_q  <= sel_y;
      fma_z_q  <= sel_z;
      fma_op_q <= sel_op;
      fma_rm_q <= sel_rm;
    end
  end

  // Response registers: id tagged at accept, data captured after the hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_id_q     <= '0;
    end else begin
      if (accept) rsp_id_q <= grant;
      if (capture) begin
        rsp_result_q <= fma_result;
        rsp_flags_q  <= fma_flags;
        rsp_valid_q  <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid_q  <= 1'b0;
      end
    end
  end

  // Sticky accrued flags; a clear coinciding with capture keeps the new flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_flags_q <= '0;
    end else if (capture) begin
      acc_flags_q <= (flag_clr ? 4'b0000 : acc_flags_q) | fma_flags;
    end else if (flag_clr) begin
      acc_flags_q <= '0;
    end
  end

  assign fma_x      = fma_x_q;
  assign fma_y      = fma_y_q;
  assign fma_z      = fma_z_q;
  assign fma_mul    = fma_op_q[3];
  assign fma_add    = fma_op_q[2];
  assign fma_negr   = fma_op_q[1];
  assign fma_negz   = fma_op_q[0];
  assign fma_rm     = fma_rm_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_id     = rsp_id_q;
  assign acc_flags  = acc_flags_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/fma16_arbiter.md
Name: fma16_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational fma16 datapath among NREQ requesters.
- Each requester issues an operand set and an op over a valid/ready handshake.
- The arbiter registers the operands onto the fma16 inputs and holds them for MC_CYCLES cycles, so fma16 closes as a multicycle path. It then captures the result and flags and returns them over a valid/ready response channel tagged with the requester id.
- Also maintains a sticky accrued-flags register (fflags-style).

Parameters:
- NREQ, 4, number of requesters (>=2).
- MC_CYCLES, 2, cycles the fma16 inputs are held stable before capture (>=1).
- IDW, $clog2(NREQ), requester id width.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept (at most one bit high)
- req_x, req_y, req_z  input  16*NREQ each  fp16 operands; requester i occupies bits [16i+15:16i]
- req_op  input  4*NREQ  {mul,add,negr,negz} per requester
- req_rm  input  2*NREQ  roundmode per requester
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_result  output  16  fp16 result
- rsp_flags  output  4  {nv,of,uf,nx}
- rsp_id  output  IDW  index of the requester that owns the response
- fma_x, fma_y, fma_z  output  16 each  registered operands to fma16
- fma_mul, fma_add, fma_negr, fma_negz  output  1 each  registered op controls to fma16
- fma_rm  output  2  registered roundmode to fma16
- fma_result  input  16  fma16 result
- fma_flags  input  4  fma16 flags
- acc_flags  output  4  sticky OR of all captured flags
- flag_clr  input  1  clear acc_flags
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE. The following are all zero: req_ready, rsp_valid, rsp_result, rsp_flags, rsp_id, all fma_* outputs, acc_flags, busy. Round-robin pointer rr=0.
- Reset mid-operation: the in-flight operation is dropped and no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant g = first index with req_valid set, searching from rr upward and wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle. All other bits are 0; all bits are 0 if no req_valid is set.
  - On the accept edge: latch g's operands, op and rm into the fma_* registers; rsp_id<=g; rr<=(g+1) mod NREQ; counter<=MC_CYCLES-1; go to EXEC.
- EXEC:
  - fma_* outputs are held stable and req_ready is all 0.
  - When counter==0: rsp_result<=fma_result; rsp_flags<=fma_flags; rsp_valid<=1; go to RESP. Otherwise counter decrements.
- RESP:
  - rsp_* outputs are held stable and req_ready is all 0.
  - On rsp_valid & rsp_ready: rsp_valid<=0; go to IDLE.
  - The earliest next accept is the following cycle.
- Latency: accept at end of cycle N gives rsp_valid high from cycle N+MC_CYCLES+1.
- Throughput: one operation per MC_CYCLES+2 cycles with rsp_ready held high.
- Requester rules: req_valid and its operands must be stable until accepted. Dropping req_valid before accept is legal and leaves no state.
- Fairness: the requester granted last has the lowest priority next time. A requester that holds req_valid waits at most NREQ-1 grants.
- acc_flags: on each capture edge, acc_flags <= (flag_clr ? 0 : acc_flags) | fma_flags. On other edges, flag_clr=1 gives 0.
- The fma_* registers keep their last values after capture and are not cleared. The rsp_* registers hold until the next capture.

Test Plan:
- fmadd, normal path: NREQ=4, MC_CYCLES=2, requester 1 sends x=0x4000, y=0x4200, z=0x3C00, op=4'b1100, rm=0. Required: req_ready=4'b0010 in the same cycle; rsp_valid 3 cycles after accept; rsp_result=0x4700, rsp_flags=0, rsp_id=1.
- Overflow: fmul x=0x7BFF, y=0x4000, op=4'b1000. Required: rsp_result=0x7C00, rsp_flags=4'b0101, acc_flags=4'b0101. A following flag_clr pulse gives acc_flags=0.
- Invalid: fmul x=0x7C00, y=0x0000. Required: rsp_result=0x7E00, rsp_flags=4'b1000. acc_flags ORs with the prior value.
- Round-robin: all 4 req_valid held high after reset with rsp_ready=1. Required: grant order 0,1,2,3,0 and rsp_id in the same order.
- Backpressure: rsp_ready=0 for 10 cycles while requesters 0 and 2 are valid. Required: rsp_* held constant; req_ready=0 throughout; busy=1. After rsp_ready rises, IDLE for 1 cycle, then the next grant.
- Reset mid-EXEC: assert reset_n=0 during EXEC. Required: all outputs 0 immediately; no rsp_valid after release; the next grant starts at requester 0.
